// File: rtl/i2c_reg_arbiter_pkg.sv
// Shared definitions for the I2C/host register arbiter.
//   - FSM state encoding, port-select constants, bus widths,
//     default register reset value and out-of-range read value.
package i2c_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] RESET_VAL_DEF = 8'h00;
  localparam logic [BYTE_W-1:0] OOR_RDATA     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_I2C  = 2'd1,
    GNT_HOST = 2'd2,
    RESP     = 2'd3
  } arbState_t;

  typedef enum logic {
    PORT_I2C  = 1'b0,
    PORT_HOST = 1'b1
  } port_t;

endpackage

// File: rtl/i2c_reg_arbiter_if.sv
// Request/response bundle between the two requesters (I2C slave FSM,
// host glue) and the register arbiter.
//   slave  : arbiter side (takes requests, drives grants/read data)
//   master : requester side
interface i2c_reg_arbiter_if;
  import i2c_pkg::*;

  logic              i2c_req;
  logic              i2c_we;
  logic [ADDR_W-1:0] i2c_addr;
  logic [BYTE_W-1:0] i2c_wdata;
  logic              i2c_lock;
  logic              i2c_gnt;
  logic              i2c_rvalid;
  logic [BYTE_W-1:0] i2c_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [BYTE_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [BYTE_W-1:0] host_rdata;

  logic              addr_err;

  modport slave (
    input  i2c_req, i2c_we, i2c_addr, i2c_wdata, i2c_lock,
    input  host_req, host_we, host_addr, host_wdata,
    output i2c_gnt, i2c_rvalid, i2c_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output addr_err
  );

  modport master (
    output i2c_req, i2c_we, i2c_addr, i2c_wdata, i2c_lock,
    output host_req, host_we, host_addr, host_wdata,
    input  i2c_gnt, i2c_rvalid, i2c_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  addr_err
  );

endinterface

// File: rtl/i2c_reg_bank.sv
// Register bank: NUM_REGS x DATA_W flops, one synchronous write port,
// one combinational read port and an address in-range flag.
//   CLK, RST        : clock, async active-high reset (all regs -> RESET_VAL)
//   wrEn/wrData     : write strobe and data (caller gates with inRange)
//   addr            : shared read/write address
//   rdData, inRange : read data of reg[addr], addr < NUM_REGS
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int unsigned      NUM_REGS  = 16,
  parameter int unsigned      DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              inRange
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]  idx;

  assign idx     = addr[IDX_W-1:0];
  // Extra bit keeps the compare correct when NUM_REGS = 256.
  assign inRange = ({1'b0, addr} < CMP_W'(NUM_REGS));
  assign rdData  = regs[idx];

  // Storage; out-of-range writes are dropped here as well as by the caller.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wrEn && inRange) begin
      regs[idx] <= wrData;
    end
  end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates single-register accesses between the I2C slave port and the
// local host port, round-robin on contention, with host grants blocked
// while the I2C transaction lock is held.
//   CLK, RST : clock, async active-high reset
//   bus      : request/response bundle (slave modport)
module i2c_reg_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned      NUM_REGS  = 16,
  parameter int unsigned      DATA_W    = 8,
  parameter logic [BYTE_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  i2c_reg_arbiter_if.slave bus
);

  arbState_t state, nextState;
  port_t     lastWinner;

  logic              i2cElig, hostElig;
  logic              inGnt, selHost;
  logic              accWe;
  logic [ADDR_W-1:0] accAddr;
  logic [BYTE_W-1:0] accWdata;
  logic [BYTE_W-1:0] bankRd, rdVal;
  logic              inRange;
  logic              wrEn;

  assign i2cElig  = bus.i2c_req;
  assign hostElig = bus.host_req && !bus.i2c_lock;

  // Access mux: the granted side's request signals drive the bank.
  assign inGnt    = (state == GNT_I2C) || (state == GNT_HOST);
  assign selHost  = (state == GNT_HOST);
  assign accWe    = selHost ? bus.host_we    : bus.i2c_we;
  assign accAddr  = selHost ? bus.host_addr  : bus.i2c_addr;
  assign accWdata = selHost ? bus.host_wdata : bus.i2c_wdata;
  assign wrEn     = inGnt && accWe && inRange;
  assign rdVal    = inRange ? bankRd : OOR_RDATA;

  i2c_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .CLK     (CLK),
    .RST     (RST),
    .wrEn    (wrEn),
    .addr    (accAddr),
    .wrData  (accWdata),
    .rdData  (bankRd),
    .inRange (inRange)
  );

  // State and fairness registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lastWinner <= PORT_HOST;
    end else begin
      state <= nextState;
      if (state == GNT_I2C) begin
        lastWinner <= PORT_I2C;
      end else if (state == GNT_HOST) begin
        lastWinner <= PORT_HOST;
      end
    end
  end

  // Next-state: on contention the side that did not win last time goes first.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (i2cElig && hostElig) begin
          nextState = (lastWinner == PORT_HOST) ? GNT_I2C : GNT_HOST;
        end else if (i2cElig) begin
          nextState = GNT_I2C;
        end else if (hostElig) begin
          nextState = GNT_HOST;
        end
      end
      GNT_I2C, GNT_HOST: nextState = RESP;
      RESP:              nextState = IDLE;
      default:           nextState = IDLE;
    endcase
  end

  // Registered responses: grant aligned with GNT_x, rvalid/addr_err with RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.i2c_gnt     <= 1'b0;
      bus.host_gnt    <= 1'b0;
      bus.i2c_rvalid  <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.i2c_rdata   <= '0;
      bus.host_rdata  <= '0;
      bus.addr_err    <= 1'b0;
    end else begin
      bus.i2c_gnt     <= (state == IDLE) && (nextState == GNT_I2C);
      bus.host_gnt    <= (state == IDLE) && (nextState == GNT_HOST);
      bus.i2c_rvalid  <= (state == GNT_I2C)  && !accWe;
      bus.host_rvalid <= (state == GNT_HOST) && !accWe;
      bus.addr_err    <= inGnt && !inRange;
      if ((state == GNT_I2C) && !accWe) begin
        bus.i2c_rdata <= rdVal;
      end
      if ((state == GNT_HOST) && !accWe) begin
        bus.host_rdata <= rdVal;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Self-checking bench for i2c_reg_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_i2c_reg_arbiter;
  import i2c_pkg::*;

  localparam int unsigned NREGS  = 16;
  localparam int          BUDGET = 200;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  i2c_reg_arbiter_if bus ();

  i2c_reg_arbiter #(
    .NUM_REGS  (NREGS),
    .DATA_W    (8),
    .RESET_VAL (8'h00)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int errPulses = 0;

  // Model state: register contents, fairness, and where the current access is.
  logic [7:0] mem [NREGS];
  int         phase;          // 0 idle, 1 granted, 2 responding
  logic       lastHost;
  logic       curHost, curWe;
  logic [7:0] curAddr, curWd;
  logic [7:0] expRdI, expRdH;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always begin : monitor
    logic       sRI, sWI, sRH, sWH, sLk;
    logic [7:0] sAI, sDI, sAH, sDH;
    logic       eGI, eGH, eVI, eVH, eEr, eligI, eligH, winHost;
    logic [7:0] rv;
    @(posedge CLK);
    cyc++;
    sRI = bus.i2c_req;  sWI = bus.i2c_we;  sAI = bus.i2c_addr;  sDI = bus.i2c_wdata;
    sRH = bus.host_req; sWH = bus.host_we; sAH = bus.host_addr; sDH = bus.host_wdata;
    sLk = bus.i2c_lock;
    #1;
    eGI = 1'b0; eGH = 1'b0; eVI = 1'b0; eVH = 1'b0; eEr = 1'b0;
    if (RST) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] = 8'h00;
      phase = 0; lastHost = 1'b1; expRdI = 8'h00; expRdH = 8'h00;
    end else begin
      if (phase == 0) begin
        eligI = sRI;
        eligH = sRH && !sLk;
        if (eligI || eligH) begin
          winHost  = (eligI && eligH) ? !lastHost : eligH;
          lastHost = winHost;
          curHost  = winHost;
          curWe    = winHost ? sWH : sWI;
          curAddr  = winHost ? sAH : sAI;
          curWd    = winHost ? sDH : sDI;
          eGI      = !winHost;
          eGH      = winHost;
          phase    = 1;
        end
      end else if (phase == 1) begin
        rv = 8'hFF;
        if (curAddr < 8'(NREGS)) begin
          if (curWe) mem[curAddr[3:0]] = curWd;
          else       rv = mem[curAddr[3:0]];
        end
        eEr = (curAddr >= 8'(NREGS));
        if (!curWe) begin
          if (curHost) begin eVH = 1'b1; expRdH = rv; end
          else         begin eVI = 1'b1; expRdI = rv; end
        end
        phase = 2;
      end else begin
        phase = 0;
      end
    end
    chk("i2c_gnt",     32'(bus.i2c_gnt),     32'(eGI));
    chk("host_gnt",    32'(bus.host_gnt),    32'(eGH));
    chk("i2c_rvalid",  32'(bus.i2c_rvalid),  32'(eVI));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(eVH));
    chk("addr_err",    32'(bus.addr_err),    32'(eEr));
    chk("i2c_rdata",   32'(bus.i2c_rdata),   32'(expRdI));
    chk("host_rdata",  32'(bus.host_rdata),  32'(expRdH));
    if (bus.addr_err) errPulses++;
  end

  // One access on one port; returns data seen in the response cycle.
  task automatic access(input bit host, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output int reqCyc, output int gntCyc);
    bit got;
    @(negedge CLK);
    if (host) begin
      bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd; bus.host_req = 1'b1;
    end else begin
      bus.i2c_we = we;  bus.i2c_addr = addr;  bus.i2c_wdata = wd;  bus.i2c_req = 1'b1;
    end
    reqCyc = cyc;
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      @(posedge CLK); #1;
      got = host ? bus.host_gnt : bus.i2c_gnt;
    end
    chk(host ? "host_gnt_wait" : "i2c_gnt_wait", 32'(got), 32'd1);
    gntCyc = cyc;
    @(negedge CLK);
    if (host) bus.host_req = 1'b0;
    else      bus.i2c_req  = 1'b0;
    @(posedge CLK); #1;
    rd = host ? bus.host_rdata : bus.i2c_rdata;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rd, rdI, rdH;
    int rq, gc, rqI, gI, rqH, gH, e0, lk0, cycDrop;
    bit got;

    RST = 1'b1;
    bus.i2c_req = 1'b0; bus.i2c_we = 1'b0; bus.i2c_addr = '0; bus.i2c_wdata = '0;
    bus.i2c_lock = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Host write then I2C read of the same register.
    access(1'b1, 1'b1, 8'd3, 8'hA5, rd, rq, gc);
    chk("host_gnt_latency", 32'(gc - rq), 32'd1);
    access(1'b0, 1'b0, 8'd3, 8'h00, rd, rq, gc);
    chk("i2c_rd_a5", 32'(rd), 32'hA5);
    chk("i2c_rvalid_after_gnt", 32'(bus.i2c_rvalid), 32'd1);

    // Fresh reset so the first contention uses reset priority.
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    repeat (2) begin
      fork
        access(1'b0, 1'b0, 8'd0, 8'h00, rdI, rqI, gI);
        access(1'b1, 1'b0, 8'd1, 8'h00, rdH, rqH, gH);
      join
      chk("contend_i2c_first", 32'(gI < gH), 32'd1);
      chk("contend_gap", 32'(gH - gI), 32'd3);
    end

    // Out-of-range write and read.
    e0 = errPulses;
    access(1'b1, 1'b1, 8'd20, 8'h77, rd, rq, gc);
    access(1'b1, 1'b0, 8'd20, 8'h00, rd, rq, gc);
    @(negedge CLK);
    chk("oor_rdata", 32'(rd), 32'hFF);
    chk("oor_err_count", 32'(errPulses - e0), 32'd2);
    for (int i = 0; i < int'(NREGS); i++) begin
      access(1'b1, 1'b0, 8'(i), 8'h00, rd, rq, gc);
      chk("reg_unchanged", 32'(rd), 32'h00);
    end

    // Lock held ~20 cycles with host pending; I2C served meanwhile.
    @(negedge CLK); bus.i2c_lock = 1'b1; lk0 = cyc; cycDrop = 0;
    fork
      access(1'b1, 1'b0, 8'd5, 8'h00, rdH, rqH, gH);
      begin
        access(1'b0, 1'b1, 8'd5, 8'h5A, rd, rq, gc);
        access(1'b0, 1'b0, 8'd5, 8'h00, rdI, rqI, gI);
        while (cyc < lk0 + 20) @(negedge CLK);
        bus.i2c_lock = 1'b0;
        cycDrop = cyc;
      end
    join
    chk("lock_i2c_rd", 32'(rdI), 32'h5A);
    chk("host_gnt_after_unlock", 32'(gH), 32'(cycDrop + 1));
    chk("host_rd_after_lock", 32'(rdH), 32'h5A);

    // Reset during the grant cycle of a host write.
    @(negedge CLK);
    bus.host_we = 1'b1; bus.host_addr = 8'd2; bus.host_wdata = 8'h3C; bus.host_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      @(posedge CLK); #1;
      got = bus.host_gnt;
    end
    chk("rst_gnt_wait", 32'(got), 32'd1);
    #1 RST = 1'b1;
    bus.host_req = 1'b0;
    @(posedge CLK); #1;
    chk("no_rvalid_after_rst", 32'(bus.host_rvalid), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    access(1'b1, 1'b0, 8'd2, 8'h00, rd, rq, gc);
    chk("rst_dropped_write", 32'(rd), 32'h00);

    // Random mixed traffic with occasional lock pulses.
    repeat (150) begin
      fork
        begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          access(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)),
                 8'($urandom), rdI, rqI, gI);
        end
        begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          access(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)),
                 8'($urandom), rdH, rqH, gH);
        end
        begin
          if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK); bus.i2c_lock = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge CLK);
            bus.i2c_lock = 1'b0;
          end
        end
      join
    end

    repeat (4) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
